// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared types and constants for the SD-over-SPI command framer.
package sd_cmd_pkg;
  typedef enum logic [1:0] {IDLE, ARG, CRC, DONE} state_t;
  localparam logic [1:0] START_PAT = 2'b01;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int ARG_BYTES_DEF = 4;
  function automatic int cmd_bytes(input int arg_bytes);
    return arg_bytes + 2;
  endfunction
  localparam int CMD_BYTES = cmd_bytes(ARG_BYTES_DEF);
endpackage

// File: rtl/sd_cmd_framer_if.sv
// sd_cmd_framer_if: byte-in / command-out bundle between the SPI byte receiver side and the framer.
interface sd_cmd_framer_if #(parameter int ARG_BYTES = 4);
  logic                   cs;
  logic [7:0]             byte_in;
  logic                   byte_chg;
  logic                   cmd_valid;
  logic [5:0]             cmd_index;
  logic [8*ARG_BYTES-1:0] cmd_arg;
  logic                   cmd_crc_err;
  logic                   cmd_end_err;
  logic                   busy;
  modport master (output cs, byte_in, byte_chg,
                  input cmd_valid, cmd_index, cmd_arg, cmd_crc_err, cmd_end_err, busy);
  modport slave  (input cs, byte_in, byte_chg,
                  output cmd_valid, cmd_index, cmd_arg, cmd_crc_err, cmd_end_err, busy);
endinterface

// File: rtl/sd_crc7_byte.sv
// sd_crc7_byte: one-byte CRC7 (x^7+x^3+1) update, MSB first; only built when SD_CRC_CHECK_EN is defined.
`ifdef SD_CRC_CHECK_EN
module sd_crc7_byte
  import sd_cmd_pkg::*;
(
  input  logic [6:0] crc_in,
  input  logic [7:0] data,
  output logic [6:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--)
      crc_out = {crc_out[5:0], 1'b0} ^ ((crc_out[6] ^ data[i]) ? CRC7_POLY : 7'h0);
  end
endmodule
`endif

// File: rtl/sd_cmd_framer.sv
// sd_cmd_framer: assembles start+argument+CRC byte frames into a one-cycle command pulse.
// Optional CRC7 check of the frame is enabled by defining SD_CRC_CHECK_EN.
module sd_cmd_framer
  import sd_cmd_pkg::*;
#(
  parameter int         ARG_BYTES = 4,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input logic            clk,
  input logic            rst_n,
  sd_cmd_framer_if.slave bus
);
  localparam int AW = 8 * ARG_BYTES;
  localparam int CW = $clog2(ARG_BYTES + 1);
  state_t          state_q, state_d;
  logic            chg_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [5:0]      idx_q, idx_d, cmd_index_q, cmd_index_d;
  logic [AW-1:0]   sh_q, sh_d, cmd_arg_q, cmd_arg_d;
  logic            valid_q, valid_d, crc_err_q, crc_err_d, end_err_q, end_err_d;
  logic            stb, start, last, crc_err;
  assign stb   = bus.byte_chg & ~chg_q;
  assign start = stb && state_q == IDLE && bus.byte_in != FILL_BYTE && bus.byte_in[7:6] == START_PAT;
  assign last  = cnt_q == CW'(ARG_BYTES - 1);
`ifdef SD_CRC_CHECK_EN
  logic [6:0] crc_q, crc_d, crc_nx;
  logic       take;
  // A start byte seeds the CRC from zero, so no separate clear is needed between frames.
  sd_crc7_byte u_crc (
    .crc_in (state_q == IDLE ? 7'h0 : crc_q),
    .data   (bus.byte_in),
    .crc_out(crc_nx)
  );
  assign take    = ~bus.cs & (start | (stb & state_q == ARG));
  assign crc_d   = take ? crc_nx : crc_q;
  assign crc_err = crc_q != bus.byte_in[7:1];
`else
  assign crc_err = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    cmd_index_d = cmd_index_q;
    cmd_arg_d   = cmd_arg_q;
    crc_err_d   = crc_err_q;
    end_err_d   = end_err_q;
    valid_d     = 1'b0;
    if (bus.cs) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = ARG;
          idx_d   = bus.byte_in[5:0];
        end
        ARG: if (stb) begin
          sh_d    = (sh_q << 8) | AW'(bus.byte_in);
          cnt_d   = last ? '0 : cnt_q + 1'b1;
          state_d = last ? CRC : ARG;
        end
        CRC: if (stb) begin
          state_d     = DONE;
          valid_d     = 1'b1;
          cmd_index_d = idx_q;
          cmd_arg_d   = sh_q;
          crc_err_d   = crc_err;
          end_err_d   = ~bus.byte_in[0];
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      chg_q       <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      cmd_index_q <= '0;
      cmd_arg_q   <= '0;
      valid_q     <= 1'b0;
      crc_err_q   <= 1'b0;
      end_err_q   <= 1'b0;
`ifdef SD_CRC_CHECK_EN
      crc_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      chg_q       <= bus.byte_chg;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      cmd_index_q <= cmd_index_d;
      cmd_arg_q   <= cmd_arg_d;
      valid_q     <= valid_d;
      crc_err_q   <= crc_err_d;
      end_err_q   <= end_err_d;
`ifdef SD_CRC_CHECK_EN
      crc_q       <= crc_d;
`endif
    end
  end
  assign bus.cmd_valid   = valid_q;
  assign bus.cmd_index   = cmd_index_q;
  assign bus.cmd_arg     = cmd_arg_q;
  assign bus.cmd_crc_err = crc_err_q;
  assign bus.cmd_end_err = end_err_q;
  assign bus.busy        = state_q != IDLE;
endmodule

// File: tb/tb_sd_cmd_framer.sv
// tb_sd_cmd_framer: directed frames against a frame-level model checked on every cycle.
module tb_sd_cmd_framer;
  typedef struct {
    int          cyc;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        ce;
    logic        ee;
  } exp_t;
`ifdef SD_CRC_CHECK_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;
  int   n_valid = 0;
  int   busy_start = 0;
  int   busy_end = 0;
  logic [7:0] fb[$];
  exp_t exp_q[$];
  exp_t cur = '{0, 6'd0, 32'd0, 1'b0, 1'b0};
  sd_cmd_framer_if #(.ARG_BYTES(4)) bus ();
  sd_cmd_framer #(.ARG_BYTES(4), .FILL_BYTE(8'hFF)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // CRC7 as the remainder of message*x^7 divided by x^7+x^3+1
  function automatic logic [6:0] crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    if (fb.size() == 0 && b[7:6] != 2'b01) return;
    if (fb.size() == 0) begin
      busy_start = cyc + 1;
      busy_end   = 32'h7fffffff;
    end
    fb.push_back(b);
    if (fb.size() == 6) begin
      e.cyc = cyc + 1;
      e.idx = fb[0][5:0];
      e.arg = {fb[1], fb[2], fb[3], fb[4]};
      e.ce  = CRC_ON && (crc7({fb[0], e.arg}) != b[7:1]);
      e.ee  = ~b[0];
      exp_q.push_back(e);
      fb.delete();
      busy_end = cyc + 2;
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input int hi);
    @(negedge clk);
    bus.byte_in  = b;
    bus.byte_chg = 1'b1;
    model_byte(b);
    repeat (hi) @(negedge clk);
    bus.byte_chg = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic send_frame(input logic [47:0] f, input int hi);
    for (int i = 5; i >= 0; i--) send_byte(f[i*8 +: 8], hi);
  endtask
  task automatic pulse_cs(input int n);
    @(negedge clk);
    bus.cs = 1'b1;
    fb.delete();
    if (busy_end > cyc + 1) busy_end = cyc + 1;
    repeat (n) @(negedge clk);
    bus.cs = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    fb.delete();
    exp_q.delete();
    cur = '{0, 6'd0, 32'd0, 1'b0, 1'b0};
    busy_end = cyc;
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_index", 32'(bus.cmd_index), 32'd0);
    check("rst_arg", bus.cmd_arg, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask
  always @(negedge clk) begin
    logic ev, eb;
    ev = 1'b0;
    if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
      cur = exp_q.pop_front();
      ev  = 1'b1;
    end
    eb = cyc >= busy_start && cyc < busy_end;
    vectors++;
    if ({bus.cmd_valid, bus.cmd_index, bus.cmd_arg, bus.cmd_crc_err, bus.cmd_end_err, bus.busy}
        !== {ev, cur.idx, cur.arg, cur.ce, cur.ee, eb}) begin
      fails++;
      $display("FAIL cyc%0d outputs: got v=%b idx=%h arg=%h ce=%b ee=%b busy=%b want v=%b idx=%h arg=%h ce=%b ee=%b busy=%b",
               cyc, bus.cmd_valid, bus.cmd_index, bus.cmd_arg, bus.cmd_crc_err, bus.cmd_end_err, bus.busy,
               ev, cur.idx, cur.arg, cur.ce, cur.ee, eb);
    end
    if (bus.cmd_valid === 1'b1) n_valid++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end
  initial begin
    bus.cs       = 1'b0;
    bus.byte_chg = 1'b0;
    bus.byte_in  = 8'hFF;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(bus.cmd_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    #2 rst_n = 1'b1;
    check("model_crc_cmd0", 32'(crc7(40'h4000000000)), 32'h4A);
    check("model_crc_cmd8", 32'(crc7(40'h48000001AA)), 32'h43);
    send_frame(48'h400000000095, 4);
    repeat (2) @(negedge clk);
    check("t1_count", n_valid, 1);
    check("t1_index", 32'(bus.cmd_index), 32'd0);
    check("t1_errs", {bus.cmd_crc_err, bus.cmd_end_err}, 32'd0);
    send_byte(8'hFF, 4);
    send_byte(8'hFF, 4);
    send_frame(48'h48000001AA87, 4);
    repeat (2) @(negedge clk);
    check("t2_count", n_valid, 2);
    check("t2_index", 32'(bus.cmd_index), 32'd8);
    check("t2_arg", bus.cmd_arg, 32'h000001AA);
    send_frame(48'h400000000097, 4);
    repeat (2) @(negedge clk);
    check("t3_crc_err", 32'(bus.cmd_crc_err), 32'(CRC_ON));
    check("t3_end_ok", 32'(bus.cmd_end_err), 32'd0);
    send_frame(48'h400000000094, 4);
    repeat (2) @(negedge clk);
    check("t3_end_err", 32'(bus.cmd_end_err), 32'd1);
    check("t3_count", n_valid, 4);
    send_byte(8'h40, 4);
    send_byte(8'h00, 4);
    send_byte(8'h00, 4);
    pulse_cs(2);
    send_frame(48'h400000000095, 4);
    repeat (2) @(negedge clk);
    check("t4_count", n_valid, 5);
    check("t4_arg", bus.cmd_arg, 32'd0);
    send_frame(48'h400000000095, 20);
    repeat (2) @(negedge clk);
    check("t5_count", n_valid, 6);
    check("t5_errs", {bus.cmd_crc_err, bus.cmd_end_err}, 32'd0);
    send_frame(48'h48000001AA87, 4);
    send_byte(8'h41, 4);
    send_byte(8'h12, 4);
    send_byte(8'h34, 4);
    do_reset();
    send_frame(48'h400000000095, 4);
    repeat (2) @(negedge clk);
    check("t6_count", n_valid, 8);
    check("t6_index", 32'(bus.cmd_index), 32'd0);
    check("t6_arg", bus.cmd_arg, 32'd0);
    repeat (4) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
